// File: rtl/adder_arb_pkg.sv
// Shared constants for the adder arbiter: requester ids, buffer state encoding
// and the overflow rule used on the shared adder output.
package adder_arb_pkg;

  localparam int ID_W = 2;

  localparam logic [ID_W-1:0] REQ_BRANCH = 2'd0;
  localparam logic [ID_W-1:0] REQ_JUMP   = 2'd1;
  localparam logic [ID_W-1:0] REQ_ADDR   = 2'd2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Signed requesters flag two's-complement overflow, unsigned ones the carry out.
  function automatic logic add_ofl(input logic sgn, input logic a_msb, input logic b_msb,
                                   input logic s_msb, input logic cout);
    return sgn ? ((a_msb == b_msb) && (s_msb != a_msb)) : cout;
  endfunction

endpackage

// File: rtl/adder16.sv
// Plain ripple adder with carry-in 0; the arbiter time-shares one instance
// between all requesters.
module adder16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_arb.sv
// Round-robin arbiter feeding one shared adder into a single-entry result buffer.
// Optional macro ADDER_ARB_STICKY_ERR_EN makes err a sticky overflow flag.
//
// state    | meaning
// ST_EMPTY | result buffer free, any request may be granted
// ST_FULL  | res holds a valid sum, refill only while it drains
module adder_arb
  import adder_arb_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREQ  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*WIDTH-1:0] op_a,
  input  logic [NREQ*WIDTH-1:0] op_b,
  input  logic [NREQ-1:0]      sign,
  output logic [NREQ-1:0]      gnt,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ID_W-1:0]      res_id,
  output logic [WIDTH-1:0]     res,
  output logic                 res_ofl,
  output logic                 err
);

  localparam int SEL_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state;
  state_t            state_nxt;
  logic              can_grant;
  logic              gnt_any;
  logic              found;
  logic [ID_W-1:0]   last_gnt;
  logic [ID_W-1:0]   gnt_id;
  logic [SEL_W-1:0]  sel;
  int                idx;
  logic [WIDTH-1:0]  a_sel;
  logic [WIDTH-1:0]  b_sel;
  logic              sign_sel;
  logic [WIDTH-1:0]  sum;
  logic              cout;
  logic              ofl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (gnt_any) state_nxt = ST_FULL;
      ST_FULL:  if (res_ready && !gnt_any) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    res_valid = (state == ST_FULL);
    can_grant = (state == ST_EMPTY) || res_ready;
  end

  // Search begins one past the last winner so every requester gets a turn.
  always_comb begin
    gnt    = '0;
    gnt_id = REQ_BRANCH;
    found  = 1'b0;
    idx    = 0;
    sel    = '0;
    if (!rst && can_grant) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (int'(last_gnt) + k) % NREQ;
        sel = SEL_W'(idx);
        if (!found && req[sel]) begin
          found    = 1'b1;
          gnt[sel] = 1'b1;
          gnt_id   = ID_W'(sel);
        end
      end
    end
  end

  assign gnt_any = |gnt;

  always_comb begin
    a_sel    = '0;
    b_sel    = '0;
    sign_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        a_sel    = a_sel | op_a[i*WIDTH +: WIDTH];
        b_sel    = b_sel | op_b[i*WIDTH +: WIDTH];
        sign_sel = sign_sel | sign[i];
      end
    end
  end

  adder16 #(.WIDTH(WIDTH)) u_add (
    .a    (a_sel),
    .b    (b_sel),
    .sum  (sum),
    .cout (cout)
  );

  assign ofl = add_ofl(sign_sel, a_sel[WIDTH-1], b_sel[WIDTH-1], sum[WIDTH-1], cout);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res      <= '0;
      res_ofl  <= 1'b0;
      res_id   <= REQ_BRANCH;
      last_gnt <= ID_W'(NREQ - 1);
    end else if (gnt_any) begin
      res      <= sum;
      res_ofl  <= ofl;
      res_id   <= gnt_id;
      last_gnt <= gnt_id;
    end
  end

`ifdef ADDER_ARB_STICKY_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (gnt_any && ofl) begin
      err <= 1'b1;
    end
  end
`else
  assign err = res_valid & res_ofl;
`endif

endmodule

// File: tb/tb_adder_arb.sv
// Scoreboard bench for adder_arb: directed scenarios then random traffic,
// expected sums computed with integer arithmetic and queued per grant.
module tb_adder_arb;

  typedef struct {
    logic [15:0] res;
    logic        ofl;
    logic [1:0]  id;
  } item_t;

`ifdef ADDER_ARB_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [15:0] pa[3];
  logic [15:0] pb[3];
  logic [2:0]  sg;
  logic [47:0] op_a;
  logic [47:0] op_b;
  logic [2:0]  gnt;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_id;
  logic [15:0] res;
  logic        res_ofl;
  logic        err;

  assign op_a = {pa[2], pa[1], pa[0]};
  assign op_b = {pb[2], pb[1], pb[0]};

  always #5 clk = ~clk;

  adder_arb #(.WIDTH(16), .NREQ(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .sign      (sg),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res       (res),
    .res_ofl   (res_ofl),
    .err       (err)
  );

  int    total = 0;
  int    bad   = 0;
  item_t q[$];
  bit    m_full;
  int    m_last;
  int    m_gid;
  bit    m_sticky;
  bit [2:0] pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic item_t model_add(input int id, input logic [15:0] a,
                                      input logic [15:0] b, input logic s);
    item_t it;
    int ua, ub, t, sa, sb, ss;
    ua = a;
    ub = b;
    t  = ua + ub;
    it.res = 16'(t % 65536);
    if (s) begin
      sa = (ua >= 32768) ? ua - 65536 : ua;
      sb = (ub >= 32768) ? ub - 65536 : ub;
      ss = sa + sb;
      it.ofl = (ss > 32767) || (ss < -32768);
    end else begin
      it.ofl = (t > 65535);
    end
    it.id = 2'(id);
    return it;
  endfunction

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // One cycle: check grant and occupancy against the model, then advance the model.
  task automatic step();
    int exp_id;
    logic [2:0] exp_gnt;
    @(negedge clk);
    exp_id = -1;
    if (!rst && (!m_full || res_ready)) begin
      for (int k = 1; k <= 3; k++) begin
        int idx;
        idx = (m_last + k) % 3;
        if (exp_id < 0 && req[idx]) exp_id = idx;
      end
    end
    exp_gnt = (exp_id >= 0) ? 3'(1 << exp_id) : 3'b000;
    chk("gnt", {29'd0, gnt}, {29'd0, exp_gnt});
    chk("res_valid", {31'd0, res_valid}, {31'd0, m_full});
    m_gid = exp_id;
    if (exp_id >= 0) begin
      q.push_back(model_add(exp_id, pa[exp_id], pb[exp_id], sg[exp_id]));
      m_last = exp_id;
      m_full = 1'b1;
    end else if (m_full && res_ready) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_full   = 1'b0;
    m_last   = 2;
    m_sticky = 1'b0;
    q.delete();
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      logic exp_err;
      if (res_valid) begin
        if (q.size() == 0) begin
          chk("res_unexpected", 32'd1, 32'd0);
        end else begin
          chk("res", {16'd0, res}, {16'd0, q[0].res});
          chk("res_ofl", {31'd0, res_ofl}, {31'd0, q[0].ofl});
          chk("res_id", {30'd0, res_id}, {30'd0, q[0].id});
          if (q[0].ofl) m_sticky = 1'b1;
        end
      end
      if (STICKY) exp_err = m_sticky;
      else        exp_err = res_valid && (q.size() > 0) && q[0].ofl;
      chk("err", {31'd0, err}, {31'd0, exp_err});
      if (res_valid && res_ready && q.size() > 0) void'(q.pop_front());
    end
  end

  initial begin
    logic [15:0] r0;
    rst = 1'b0;
    req = 3'b111;
    res_ready = 1'b0;
    sg = 3'b000;
    pend = 3'b000;
    for (int i = 0; i < 3; i++) begin
      pa[i] = 16'h0;
      pb[i] = 16'h0;
    end
    model_reset();
    m_gid = -1;

    // reset values, grant masked while rst is high
    #2 rst = 1'b1;
    #5;
    chk("rst_gnt", {29'd0, gnt}, 32'd0);
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res", {16'd0, res}, 32'd0);
    chk("rst_ofl", {31'd0, res_ofl}, 32'd0);
    chk("rst_id", {30'd0, res_id}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // all requesting, consumer always ready: 0,1,2,0
    req = 3'b111;
    res_ready = 1'b1;
    pa[0] = 16'h0001; pb[0] = 16'h0002;
    pa[1] = 16'h0100; pb[1] = 16'h0200;
    pa[2] = 16'h1000; pb[2] = 16'h2000;
    #1 chk("rr_first", {29'd0, gnt}, 32'd1);
    step();
    chk("rr_id0", {30'd0, res_id}, 32'd0);
    chk("rr_second", {29'd0, gnt}, 32'd2);
    step();
    chk("rr_id1", {30'd0, res_id}, 32'd1);
    chk("rr_third", {29'd0, gnt}, 32'd4);
    step();
    chk("rr_id2", {30'd0, res_id}, 32'd2);
    chk("rr_fourth", {29'd0, gnt}, 32'd1);
    step();
    chk("rr_id0b", {30'd0, res_id}, 32'd0);

    // unsigned carry out
    req = 3'b010;
    pa[1] = 16'h0010; pb[1] = 16'hFFF0; sg = 3'b000;
    step();
    chk("carry_res", {16'd0, res}, 32'h0000);
    chk("carry_ofl", {31'd0, res_ofl}, 32'd1);
    chk("carry_id", {30'd0, res_id}, 32'd1);

    // signed overflow, then a clean result
    req = 3'b001;
    pa[0] = 16'h7FFF; pb[0] = 16'h0001; sg = 3'b001;
    step();
    chk("sovf_res", {16'd0, res}, 32'h8000);
    chk("sovf_ofl", {31'd0, res_ofl}, 32'd1);
    chk("sovf_err", {31'd0, err}, 32'd1);
    req = 3'b100;
    pa[2] = 16'h0001; pb[2] = 16'h0001; sg = 3'b000;
    step();
    chk("clean_res", {16'd0, res}, 32'h0002);
    chk("clean_err", {31'd0, err}, {31'd0, STICKY});
    req = 3'b000;
    step();
    chk("drain_err", {31'd0, err}, {31'd0, STICKY});

    // back-pressure: held result, no grants, then drain-and-refill
    req = 3'b001;
    res_ready = 1'b0;
    pa[0] = 16'h1234; pb[0] = 16'h1111; sg = 3'b000;
    step();
    r0 = res;
    chk("bp_res", {16'd0, r0}, 32'h2345);
    req = 3'b110;
    pa[1] = 16'h0003; pb[1] = 16'h0004;
    pa[2] = 16'h0005; pb[2] = 16'h0006;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("bp_stable", {16'd0, res}, {16'd0, r0});
    end
    res_ready = 1'b1;
    #1 chk("bp_refill_gnt", {29'd0, gnt}, 32'd2);
    step();
    chk("bp_refill_valid", {31'd0, res_valid}, 32'd1);
    chk("bp_refill_id", {30'd0, res_id}, 32'd1);

    // asynchronous reset mid-cycle while full
    req = 3'b000;
    res_ready = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, res_valid}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    model_reset();
    req = 3'b111;
    #1 chk("arst_gnt", {29'd0, gnt}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    res_ready = 1'b1;
    #1 chk("arst_next_gnt", {29'd0, gnt}, 32'd1);
    step();

    // idle while empty: last grant must be remembered
    req = 3'b000;
    step();
    for (int c = 0; c < 10; c++) begin
      step();
      chk("idle_valid", {31'd0, res_valid}, 32'd0);
    end
    req = 3'b111;
    #1 chk("idle_resume_gnt", {29'd0, gnt}, 32'd2);
    step();

    // random traffic with held requests
    req = 3'b000;
    res_ready = 1'b1;
    step();
    step();
    for (int n = 0; n < 1500; n++) begin
      res_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          pa[i]   = rnd_op();
          pb[i]   = rnd_op();
          sg[i]   = 1'($urandom_range(0, 1));
        end
      end
      req = pend;
      step();
      if (m_gid >= 0) pend[m_gid] = 1'b0;
    end

    req = 3'b000;
    res_ready = 1'b1;
    for (int c = 0; c < 3; c++) step();
    chk("queue_drained", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
